// File: rtl/rtc_bus_master_if.sv
// Requestor and multiplexed RTC bus signals seen by rtc_bus_master.
// The master modport is the engine; the slave modport is the requestor/bus side.
interface rtc_bus_master_if #(
    parameter int NUM_CH = 3,
    parameter int DW     = 8,
    parameter int CHW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic [NUM_CH-1:0]    req;
    logic [NUM_CH-1:0]    req_we;
    logic [NUM_CH*DW-1:0] req_addr;
    logic [NUM_CH*DW-1:0] req_wdata;
    logic [NUM_CH-1:0]    done;
    logic [DW-1:0]        rd_data;
    logic                 rd_valid;
    logic [CHW-1:0]       rd_ch;
    logic                 busy;
    logic                 cs_n;
    logic                 rd_n;
    logic                 wr_n;
    logic                 ad_sel;
    logic [DW-1:0]        ad_out;
    logic                 ad_oe;
    logic [DW-1:0]        ad_in;

    modport master (
        input  req, req_we, req_addr, req_wdata, ad_in,
        output done, rd_data, rd_valid, rd_ch, busy,
               cs_n, rd_n, wr_n, ad_sel, ad_out, ad_oe
    );

    modport slave (
        output req, req_we, req_addr, req_wdata, ad_in,
        input  done, rd_data, rd_valid, rd_ch, busy,
               cs_n, rd_n, wr_n, ad_sel, ad_out, ad_oe
    );
endinterface

// File: rtl/rtc_bus_master.sv
// Multi-requestor transaction engine for the RTC multiplexed address/data bus.
// One grant per transaction: ADDR, GAP, DATA phases, then a TURN gap before done.
module rtc_bus_master #(
    parameter int NUM_CH    = 3,
    parameter int ARB_MODE  = 0,
    parameter int PHASE_CYC = 10,
    parameter int TURN_CYC  = 4,
    parameter int DW        = 8
) (
    input  logic             clk,
    input  logic             Reset,
    rtc_bus_master_if.master bus
);
    localparam int CHW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int MAXC = (PHASE_CYC > TURN_CYC) ? PHASE_CYC : TURN_CYC;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] PH_LAST = CW'(PHASE_CYC - 1);
    localparam logic [CW-1:0] TU_LAST = CW'(TURN_CYC - 1);

    typedef enum logic [2:0] {IDLE, ADDR, GAP, DATA, TURN} state_e;

    state_e         state_q;
    logic [CW-1:0]  cnt_q;
    logic [CHW-1:0] ptr_q;
    logic [CHW-1:0] ch_q;
    logic           we_q;
    logic [DW-1:0]  wdata_q;
    logic [DW-1:0]  cap_q;

    logic              cs_n_q, rd_n_q, wr_n_q, ad_sel_q, ad_oe_q;
    logic [DW-1:0]     ad_out_q;
    logic [NUM_CH-1:0] done_q;
    logic [DW-1:0]     rd_data_q;
    logic              rd_valid_q;
    logic [CHW-1:0]    rd_ch_q;
    logic              busy_q;

    int             arb_idx;
    logic           gnt_vld_d;
    logic [CHW-1:0] gnt_ch_d;
    logic [CHW-1:0] ptr_nxt_d;
    logic           gnt_we_d;
    logic [DW-1:0]  gnt_addr_d;
    logic [DW-1:0]  gnt_wdata_d;
    logic           fin_d;
    logic [DW-1:0]  fin_rdata_d;

    // Fixed priority scans from 0; round robin scans from the pointer, wrapping.
    always_comb begin
        gnt_vld_d   = 1'b0;
        gnt_ch_d    = '0;
        ptr_nxt_d   = '0;
        gnt_we_d    = 1'b0;
        gnt_addr_d  = '0;
        gnt_wdata_d = '0;
        arb_idx     = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            arb_idx = (ARB_MODE == 1) ? (int'(ptr_q) + k) % NUM_CH : k;
            if (!gnt_vld_d && bus.req[arb_idx]) begin
                gnt_vld_d   = 1'b1;
                gnt_ch_d    = CHW'(arb_idx);
                ptr_nxt_d   = CHW'((arb_idx + 1) % NUM_CH);
                gnt_we_d    = bus.req_we[arb_idx];
                gnt_addr_d  = bus.req_addr[arb_idx*DW +: DW];
                gnt_wdata_d = bus.req_wdata[arb_idx*DW +: DW];
            end
        end
    end

    // Completion is registered so it lands on the last TURN cycle; with a
    // one-cycle TURN the captured sample is taken straight from the bus.
    assign fin_d = ((TURN_CYC == 1) && (state_q == DATA) && (cnt_q == '0)) ||
                   ((TURN_CYC > 1) && (state_q == TURN) && (cnt_q == CW'(1)));
    assign fin_rdata_d = (state_q == DATA) ? bus.ad_in : cap_q;

    always_ff @(posedge clk) begin
        if (state_q == IDLE && gnt_vld_d) wdata_q <= gnt_wdata_d;
        if (state_q == DATA && cnt_q == '0) cap_q <= bus.ad_in;
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ptr_q      <= '0;
            ch_q       <= '0;
            we_q       <= 1'b0;
            cs_n_q     <= 1'b1;
            rd_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            ad_sel_q   <= 1'b0;
            ad_oe_q    <= 1'b0;
            ad_out_q   <= '0;
            done_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_ch_q    <= '0;
            busy_q     <= 1'b0;
        end else begin
            done_q     <= '0;
            rd_valid_q <= 1'b0;
            case (state_q)
                IDLE: if (gnt_vld_d) begin
                    state_q  <= ADDR;
                    cnt_q    <= PH_LAST;
                    ch_q     <= gnt_ch_d;
                    we_q     <= gnt_we_d;
                    if (ARB_MODE == 1) ptr_q <= ptr_nxt_d;
                    busy_q   <= 1'b1;
                    cs_n_q   <= 1'b0;
                    wr_n_q   <= 1'b0;
                    rd_n_q   <= 1'b1;
                    ad_sel_q <= 1'b0;
                    ad_oe_q  <= 1'b1;
                    ad_out_q <= gnt_addr_d;
                end
                ADDR: if (cnt_q == '0) begin
                    state_q  <= GAP;
                    cnt_q    <= PH_LAST;
                    cs_n_q   <= 1'b1;
                    wr_n_q   <= 1'b1;
                    ad_sel_q <= 1'b1;
                end else cnt_q <= cnt_q - 1'b1;
                GAP: if (cnt_q == '0) begin
                    state_q <= DATA;
                    cnt_q   <= PH_LAST;
                    cs_n_q  <= 1'b0;
                    if (we_q) begin
                        wr_n_q   <= 1'b0;
                        ad_oe_q  <= 1'b1;
                        ad_out_q <= wdata_q;
                    end else begin
                        rd_n_q  <= 1'b0;
                        ad_oe_q <= 1'b0;
                    end
                end else cnt_q <= cnt_q - 1'b1;
                DATA: if (cnt_q == '0) begin
                    state_q  <= TURN;
                    cnt_q    <= TU_LAST;
                    cs_n_q   <= 1'b1;
                    rd_n_q   <= 1'b1;
                    wr_n_q   <= 1'b1;
                    ad_oe_q  <= 1'b0;
                    ad_sel_q <= 1'b0;
                end else cnt_q <= cnt_q - 1'b1;
                TURN: if (cnt_q == '0) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end else cnt_q <= cnt_q - 1'b1;
                default: state_q <= IDLE;
            endcase
            if (fin_d) begin
                done_q <= NUM_CH'(1) << ch_q;
                if (!we_q) begin
                    rd_valid_q <= 1'b1;
                    rd_ch_q    <= ch_q;
                    rd_data_q  <= fin_rdata_d;
                end
            end
        end
    end

    assign bus.cs_n     = cs_n_q;
    assign bus.rd_n     = rd_n_q;
    assign bus.wr_n     = wr_n_q;
    assign bus.ad_sel   = ad_sel_q;
    assign bus.ad_oe    = ad_oe_q;
    assign bus.ad_out   = ad_out_q;
    assign bus.done     = done_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_ch    = rd_ch_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_rtc_bus_master.sv
// Directed bench for rtc_bus_master: one fixed-priority and one round-robin
// instance, PHASE_CYC=4 and TURN_CYC=2, cycle 0 being the grant cycle.
module tb_rtc_bus_master;
    localparam int NCH = 3;
    localparam int DW  = 8;
    localparam int P   = 4;
    localparam int T   = 2;

    logic clk = 1'b0;
    logic Reset;
    int   checks = 0;
    int   errors = 0;
    int   nfp, nrr;

    always #5 clk = ~clk;

    rtc_bus_master_if #(.NUM_CH(NCH), .DW(DW)) if_fp ();
    rtc_bus_master_if #(.NUM_CH(NCH), .DW(DW)) if_rr ();

    rtc_bus_master #(.NUM_CH(NCH), .ARB_MODE(0), .PHASE_CYC(P), .TURN_CYC(T), .DW(DW))
        u_fp (.clk(clk), .Reset(Reset), .bus(if_fp.master));
    rtc_bus_master #(.NUM_CH(NCH), .ARB_MODE(1), .PHASE_CYC(P), .TURN_CYC(T), .DW(DW))
        u_rr (.clk(clk), .Reset(Reset), .bus(if_rr.master));

    // {cs_n, rd_n, wr_n, ad_sel, ad_oe, busy, rd_valid}
    logic [6:0] fp_st, rr_st;
    assign fp_st = {if_fp.cs_n, if_fp.rd_n, if_fp.wr_n, if_fp.ad_sel, if_fp.ad_oe, if_fp.busy, if_fp.rd_valid};
    assign rr_st = {if_rr.cs_n, if_rr.rd_n, if_rr.wr_n, if_rr.ad_sel, if_rr.ad_oe, if_rr.busy, if_rr.rd_valid};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected bus status at cycle c after a grant at cycle 0.
    function automatic logic [6:0] exp_st(input int c, input logic we);
        if (c >= 1 && c <= 4)  return 7'b0100110;
        if (c >= 5 && c <= 8)  return 7'b1111110;
        if (c >= 9 && c <= 12) return we ? 7'b0101110 : 7'b0011010;
        if (c == 13)           return 7'b1110010;
        if (c == 14)           return {6'b111001, ~we};
        return 7'b1110000;
    endfunction

    task automatic run_rr(input string tag, input int ch, input logic we,
                          input logic [7:0] addr, input logic [7:0] wdata, input logic [7:0] rdval);
        if_rr.req_we = '0;
        if_rr.req_we[ch] = we;
        if_rr.req_addr[ch*DW +: DW]  = addr;
        if_rr.req_wdata[ch*DW +: DW] = wdata;
        if_rr.ad_in = 8'hAA;
        if_rr.req = NCH'(1) << ch;
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (c == 2) begin
                if_rr.req_addr[ch*DW +: DW]  = ~addr;
                if_rr.req_wdata[ch*DW +: DW] = ~wdata;
                if_rr.req_we[ch] = ~we;
            end
            if (c == 9)  if_rr.ad_in = rdval;
            if (c == 13) if_rr.ad_in = 8'h5A;
            chk($sformatf("%s_st_c%0d", tag, c), 32'(rr_st), 32'(exp_st(c, we)));
            chk($sformatf("%s_done_c%0d", tag, c), 32'(if_rr.done),
                (c == 14) ? 32'(NCH'(1) << ch) : 32'd0);
            if (c <= 8)
                chk($sformatf("%s_addr_c%0d", tag, c), 32'(if_rr.ad_out), 32'(addr));
            else if (c <= 12 && we)
                chk($sformatf("%s_wdata_c%0d", tag, c), 32'(if_rr.ad_out), 32'(wdata));
            if (c == 14 && !we) begin
                chk({tag, "_rd_data"}, 32'(if_rr.rd_data), 32'(rdval));
                chk({tag, "_rd_ch"}, 32'(if_rr.rd_ch), ch);
            end
            if (c == 14) if_rr.req = '0;
        end
    endtask

    initial begin
        Reset = 1'b1;
        if_fp.req = '0; if_fp.req_we = '0; if_fp.req_addr = '0; if_fp.req_wdata = '0; if_fp.ad_in = '0;
        if_rr.req = '0; if_rr.req_we = '0; if_rr.req_addr = '0; if_rr.req_wdata = '0; if_rr.ad_in = '0;
        tick();
        tick();
        Reset = 1'b0;
        chk("reset_fp_st", 32'(fp_st), 32'(7'b1110000));
        chk("reset_rr_st", 32'(rr_st), 32'(7'b1110000));
        chk("reset_rr_out", {if_rr.done, if_rr.ad_out, if_rr.rd_data, if_rr.rd_ch}, 32'd0);

        // Write on ch1, then read on ch2 (round-robin pointer returns to 0).
        run_rr("wr_ch1", 1, 1'b1, 8'h21, 8'h45, 8'h00);
        run_rr("rd_ch2", 2, 1'b0, 8'h22, 8'h00, 8'h37);

        // All three channels requesting continuously on both instances.
        if_fp.req_we = '0; if_rr.req_we = '0;
        if_fp.req_addr = {8'h32, 8'h31, 8'h30};
        if_rr.req_addr = {8'h32, 8'h31, 8'h30};
        if_fp.ad_in = 8'h11; if_rr.ad_in = 8'h11;
        if_fp.req = 3'b111; if_rr.req = 3'b111;
        nfp = 0; nrr = 0;
        for (int c = 1; c <= 59; c++) begin
            tick();
            if (if_fp.done != '0) nfp++;
            if (if_rr.done != '0) nrr++;
            case (c)
                14: begin
                    chk("arb_fp_g1", 32'(if_fp.done), 32'd1);
                    chk("arb_rr_g1", 32'(if_rr.done), 32'd1);
                end
                29: begin
                    chk("arb_fp_g2", 32'(if_fp.done), 32'd1);
                    chk("arb_rr_g2", 32'(if_rr.done), 32'd2);
                    chk("arb_rr_ch1", 32'(if_rr.rd_ch), 32'd1);
                end
                44: begin
                    chk("arb_fp_g3", 32'(if_fp.done), 32'd1);
                    chk("arb_rr_g3", 32'(if_rr.done), 32'd4);
                    chk("arb_rr_ch2", 32'(if_rr.rd_ch), 32'd2);
                    chk("arb_rr_rdat", 32'(if_rr.rd_data), 32'h11);
                end
                59: begin
                    chk("arb_fp_g4", 32'(if_fp.done), 32'd1);
                    chk("arb_rr_g4", 32'(if_rr.done), 32'd1);
                    if_fp.req = '0; if_rr.req = '0;
                end
                default: ;
            endcase
        end
        chk("arb_fp_count", nfp, 4);
        chk("arb_rr_count", nrr, 4);
        tick();

        // Reset during the GAP phase of a ch0 write, request kept high.
        if_rr.req_we = 3'b001;
        if_rr.req_addr[7:0] = 8'h40;
        if_rr.req_wdata[7:0] = 8'h41;
        if_rr.req = 3'b001;
        for (int c = 1; c <= 6; c++) tick();
        chk("rst_pre_st", 32'(rr_st), 32'(7'b1111110));
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("rst_c7_st", 32'(rr_st), 32'(7'b1110000));
        chk("rst_c7_out", {if_rr.done, if_rr.ad_out, if_rr.rd_data}, 32'd0);
        tick();
        chk("rst_c8_st", 32'(rr_st), 32'(7'b0100110));
        chk("rst_c8_addr", 32'(if_rr.ad_out), 32'h40);
        for (int c = 9; c <= 21; c++) begin
            tick();
            chk($sformatf("rst_done_c%0d", c), {if_rr.done, if_rr.rd_valid},
                (c == 21) ? 32'b0010 : 32'd0);
            if (c == 21) if_rr.req = '0;
        end
        tick();

        // ch0 read whose request drops on cycle 3.
        if_rr.req_we = '0;
        if_rr.req_addr[7:0] = 8'h50;
        if_rr.ad_in = 8'h66;
        if_rr.req = 3'b001;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 3) if_rr.req = '0;
            if (c == 14) begin
                chk("drop_done", {if_rr.done, if_rr.rd_valid}, 32'b0011);
                chk("drop_rdata", 32'(if_rr.rd_data), 32'h66);
            end
            if (c >= 15)
                chk($sformatf("drop_idle_c%0d", c), {if_rr.cs_n, if_rr.busy}, 32'b10);
        end

        // Reset and requests high together in IDLE.
        Reset = 1'b1;
        if_fp.req = 3'b111; if_rr.req = 3'b111;
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk($sformatf("rstreq_fp_c%0d", c), 32'(fp_st), 32'(7'b1110000));
            chk($sformatf("rstreq_rr_c%0d", c), 32'(rr_st), 32'(7'b1110000));
            chk($sformatf("rstreq_out_c%0d", c),
                {if_rr.done, if_rr.ad_out, if_rr.rd_data, if_rr.rd_ch}, 32'd0);
        end
        if_fp.req = '0; if_rr.req = '0;
        Reset = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
